// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register feeder: mode select codes,
// feeder FSM states and the nominal FIFO entry layout.
package usr_pkg;

   localparam int unsigned USR_WIDTH = 4;

   localparam logic [1:0] SEL_HOLD  = 2'b00;
   localparam logic [1:0] SEL_LEFT  = 2'b01;
   localparam logic [1:0] SEL_RIGHT = 2'b10;
   localparam logic [1:0] SEL_CLEAR = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      CLEAR = 2'b10
   } usr_state_e;

   typedef struct packed {
      logic                 clear;
      logic                 dir;
      logic [USR_WIDTH-1:0] data;
   } usr_entry_t;

endpackage

// File: rtl/usr_feed_fifo.sv
// Synchronous FIFO holding queued feeder entries; head entry is visible on o_rdata
// whenever the FIFO is non-empty.
module usr_feed_fifo #(
   parameter int unsigned ENTRY_W = 6,
   parameter int unsigned DEPTH   = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic [ENTRY_W-1:0]         i_wdata,
   output logic [ENTRY_W-1:0]         o_rdata,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   logic [ENTRY_W-1:0] r_mem [DEPTH];
   logic [PtrW-1:0]    r_wr_ptr;
   logic [PtrW-1:0]    r_rd_ptr;
   logic [CntW-1:0]    r_count;
   logic               w_push;
   logic               w_pop;

   assign o_full  = (r_count == CntW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_rdata = r_mem[r_rd_ptr];

   assign w_push = i_push && !o_full;
   assign w_pop  = i_pop && !o_empty;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PtrW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PtrW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CntW'(1);
            2'b01:   r_count <= r_count - CntW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/usr_serial_feeder.sv
// Serializes queued words onto the universal shift register's serial input while
// driving its mode select, so the register holds each word after WIDTH shifts.
module usr_serial_feeder
   import usr_pkg::*;
#(
   parameter int unsigned WIDTH = USR_WIDTH,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       i_in_valid,
   output logic                       o_in_ready,
   input  logic [WIDTH-1:0]           i_in_data,
   input  logic                       i_in_dir,
   input  logic                       i_in_clear,
   output logic [1:0]                 o_sel_out,
   output logic                       o_serial_out,
   output logic                       o_word_done,
   output logic                       o_busy,
   output logic [$clog2(DEPTH+1)-1:0] o_fifo_count
);

   localparam int unsigned CntW   = $clog2(WIDTH);
   localparam int unsigned EntryW = WIDTH + 2;

   typedef struct packed {
      logic             clear;
      logic             dir;
      logic [WIDTH-1:0] data;
   } entry_t;

   usr_state_e       r_state, w_state_nxt;
   logic [1:0]       r_sel, w_sel_nxt;
   logic             r_ser, w_ser_nxt;
   logic             r_dir, w_dir_nxt;
   logic [WIDTH-1:0] r_work, w_work_nxt;
   logic [CntW-1:0]  r_cnt, w_cnt_nxt;

   entry_t           w_wentry;
   entry_t           w_head;
   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_last;
   logic             w_pop;

   assign w_wentry = '{clear: i_in_clear, dir: i_in_dir, data: i_in_data};
   assign w_push   = i_in_valid && !w_full;

   usr_feed_fifo #(
      .ENTRY_W (EntryW),
      .DEPTH   (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_wdata (w_wentry),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (o_fifo_count)
   );

   // Pop on the final cycle of a command too, so consecutive words run without a hold gap.
   assign w_last = (r_state == CLEAR) || ((r_state == SHIFT) && (r_cnt == '0));
   assign w_pop  = ((r_state == IDLE) || w_last) && !w_empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_sel   <= SEL_HOLD;
         r_ser   <= 1'b0;
         r_dir   <= 1'b0;
         r_work  <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_sel   <= w_sel_nxt;
         r_ser   <= w_ser_nxt;
         r_dir   <= w_dir_nxt;
         r_work  <= w_work_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_sel_nxt   = r_sel;
      w_ser_nxt   = r_ser;
      w_dir_nxt   = r_dir;
      w_work_nxt  = r_work;
      w_cnt_nxt   = r_cnt;
      if (w_pop) begin
         w_dir_nxt  = w_head.dir;
         w_work_nxt = w_head.data;
         w_cnt_nxt  = CntW'(WIDTH - 1);
         if (w_head.clear) begin
            w_state_nxt = CLEAR;
            w_sel_nxt   = SEL_CLEAR;
            w_ser_nxt   = 1'b0;
         end else begin
            w_state_nxt = SHIFT;
            w_sel_nxt   = w_head.dir ? SEL_RIGHT : SEL_LEFT;
            w_ser_nxt   = w_head.dir ? w_head.data[0] : w_head.data[WIDTH-1];
         end
      end else if (w_last) begin
         w_state_nxt = IDLE;
         w_sel_nxt   = SEL_HOLD;
         w_ser_nxt   = 1'b0;
         w_cnt_nxt   = '0;
      end else if (r_state == SHIFT) begin
         w_cnt_nxt = r_cnt - CntW'(1);
         // The working register shifts toward the outgoing end; the next bit sits beside it.
         if (r_dir) begin
            w_work_nxt = r_work >> 1;
            w_ser_nxt  = r_work[1];
         end else begin
            w_work_nxt = r_work << 1;
            w_ser_nxt  = r_work[WIDTH-2];
         end
      end
   end

   assign o_in_ready   = !w_full;
   assign o_sel_out    = r_sel;
   assign o_serial_out = r_ser;
   assign o_word_done  = w_last;
   assign o_busy       = (r_state != IDLE);

endmodule

// File: tb/tb_usr_serial_feeder.sv
// Scoreboard bench for usr_serial_feeder: stimulus queues expected per-cycle outputs,
// a negedge monitor compares them and tracks a model of the downstream shift register.
module tb_usr_serial_feeder;

   localparam int unsigned WIDTH = 4;
   localparam int unsigned DEPTH = 4;

   typedef struct {
      logic [1:0] sel;
      logic       ser;
      logic       done;
      logic [3:0] word;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       i_in_valid = 1'b0;
   logic       o_in_ready;
   logic [3:0] i_in_data = '0;
   logic       i_in_dir = 1'b0;
   logic       i_in_clear = 1'b0;
   logic [1:0] o_sel_out;
   logic       o_serial_out;
   logic       o_word_done;
   logic       o_busy;
   logic [2:0] o_fifo_count;

   exp_t       sb[$];
   int         checks = 0;
   int         failures = 0;
   logic [3:0] ds = '0;
   logic       prev_busy = 1'b0;
   logic       saw_full = 1'b0;

   usr_serial_feeder #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .i_in_valid   (i_in_valid),
      .o_in_ready   (o_in_ready),
      .i_in_data    (i_in_data),
      .i_in_dir     (i_in_dir),
      .i_in_clear   (i_in_clear),
      .o_sel_out    (o_sel_out),
      .o_serial_out (o_serial_out),
      .o_word_done  (o_word_done),
      .o_busy       (o_busy),
      .o_fifo_count (o_fifo_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input bit ok, input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic expect_entry(input logic clr, input logic dir, input logic [3:0] d);
      exp_t e;
      if (clr) begin
         e.sel = 2'b11; e.ser = 1'b0; e.done = 1'b1; e.word = 4'b0000;
         sb.push_back(e);
      end else begin
         for (int i = 0; i < 4; i++) begin
            e.sel  = dir ? 2'b10 : 2'b01;
            e.ser  = dir ? d[i] : d[3-i];
            e.done = (i == 3);
            e.word = d;
            sb.push_back(e);
         end
      end
   endtask

   // Holds valid until the word is accepted; expectation is queued on acceptance.
   task automatic send(input logic clr, input logic dir, input logic [3:0] d);
      bit ok;
      ok = 1'b0;
      i_in_valid = 1'b1;
      i_in_clear = clr;
      i_in_dir   = dir;
      i_in_data  = d;
      for (int t = 0; t < 64; t++) begin
         ok = o_in_ready;
         @(posedge clk);
         #1;
         if (ok) break;
      end
      if (ok) expect_entry(clr, dir, d);
      else chk(1'b0, "send_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle();
      i_in_valid = 1'b0;
      i_in_clear = 1'b0;
   endtask

   task automatic drain(input string name);
      bit done;
      done = 1'b0;
      for (int t = 0; t < 200; t++) begin
         @(posedge clk);
         #1;
         if (sb.size() == 0 && !o_busy) begin
            done = 1'b1;
            break;
         end
      end
      chk(done, {name, "_drain"}, 32'(sb.size()), 32'd0);
      chk(o_fifo_count == 3'd0, {name, "_count_empty"}, 32'(o_fifo_count), 32'd0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         prev_busy = 1'b0;
      end else begin
         if (o_fifo_count == 3'(DEPTH)) saw_full = 1'b1;
         chk(o_in_ready == (o_fifo_count != 3'(DEPTH)), "in_ready_vs_count",
             32'(o_in_ready), 32'(o_fifo_count != 3'(DEPTH)));
         if (o_busy) begin
            if (sb.size() == 0) begin
               chk(1'b0, "unexpected_busy", 32'(o_sel_out), 32'd0);
            end else begin
               e = sb.pop_front();
               chk(o_sel_out == e.sel, "sel_out", 32'(o_sel_out), 32'(e.sel));
               chk(o_serial_out == e.ser, "serial_out", 32'(o_serial_out), 32'(e.ser));
               chk(o_word_done == e.done, "word_done", 32'(o_word_done), 32'(e.done));
               // Downstream register samples these outputs at the next rising edge.
               case (o_sel_out)
                  2'b01:   ds = {ds[2:0], o_serial_out};
                  2'b10:   ds = {o_serial_out, ds[3:1]};
                  2'b11:   ds = 4'b0000;
                  default: ds = ds;
               endcase
               if (e.done) chk(ds == e.word, "downstream_word", 32'(ds), 32'(e.word));
            end
         end else begin
            chk(o_sel_out == 2'b00 && !o_serial_out && !o_word_done, "idle_outputs",
                32'({o_sel_out, o_serial_out, o_word_done}), 32'd0);
            if (prev_busy) chk(sb.size() == 0, "no_gap", 32'(sb.size()), 32'd0);
         end
         prev_busy = o_busy;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk(o_sel_out == 2'b00, "rst_sel", 32'(o_sel_out), 32'd0);
      chk(!o_serial_out, "rst_serial", 32'(o_serial_out), 32'd0);
      chk(!o_word_done, "rst_done", 32'(o_word_done), 32'd0);
      chk(!o_busy, "rst_busy", 32'(o_busy), 32'd0);
      chk(o_fifo_count == 3'd0, "rst_count", 32'(o_fifo_count), 32'd0);
      chk(o_in_ready, "rst_ready", 32'(o_in_ready), 32'd1);
      reset = 1'b0;
      @(posedge clk);
      #1;

      send(1'b0, 1'b0, 4'b1011);
      idle();
      drain("left_1011");

      send(1'b0, 1'b1, 4'b1011);
      idle();
      drain("right_1011");

      send(1'b0, 1'b0, 4'b0110);
      send(1'b0, 1'b1, 4'b1100);
      idle();
      drain("b2b_dir_change");

      saw_full = 1'b0;
      send(1'b0, 1'b0, 4'b0001);
      send(1'b0, 1'b1, 4'b0010);
      send(1'b0, 1'b0, 4'b0100);
      send(1'b0, 1'b1, 4'b1000);
      send(1'b0, 1'b0, 4'b1001);
      send(1'b0, 1'b1, 4'b0111);
      idle();
      drain("six_words");
      chk(saw_full, "fifo_reached_full", 32'(saw_full), 32'd1);

      send(1'b0, 1'b0, 4'b1111);
      send(1'b1, 1'b0, 4'b1010);
      send(1'b0, 1'b0, 4'b0001);
      idle();
      drain("clear_seq");

      // A is on its 2nd bit with B and C queued when reset arrives.
      send(1'b0, 1'b0, 4'b1010);
      send(1'b0, 1'b1, 4'b0011);
      send(1'b0, 1'b0, 4'b1110);
      idle();
      chk(o_busy && o_fifo_count == 3'd2, "pre_reset_state", 32'(o_fifo_count), 32'd2);
      reset = 1'b1;
      sb.delete();
      @(posedge clk);
      #1;
      chk(o_sel_out == 2'b00, "midrst_sel", 32'(o_sel_out), 32'd0);
      chk(!o_busy, "midrst_busy", 32'(o_busy), 32'd0);
      chk(o_fifo_count == 3'd0, "midrst_count", 32'(o_fifo_count), 32'd0);
      chk(o_in_ready, "midrst_ready", 32'(o_in_ready), 32'd1);
      chk(!o_word_done, "midrst_done", 32'(o_word_done), 32'd0);
      reset = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      chk(!o_busy, "post_rst_quiet", 32'(o_busy), 32'd0);

      send(1'b0, 1'b1, 4'b0101);
      idle();
      drain("recovery");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
